// File: rtl/md_audio_pkg.sv
// md_audio_mixer shared types, constants and width helpers.
// Sequencer state, saturation limits, PSG bias, DC-blocker shift.
package md_audio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_P4,
    S_DC
  } seq_t;

  localparam int SAT_MAX  = 32767;
  localparam int SAT_MIN  = -32768;
  localparam int PSG_BIAS = 1024;
  localparam int DC_SHIFT = 9;
  localparam int GAIN_W   = 8;

  function automatic int acc_width(
    input int base,
    input int decim
  );
    return base + $clog2(decim);
  endfunction

  // gains are unsigned, so one extra bit keeps them positive when signed
  function automatic int prod_width(input int aw);
    return aw + GAIN_W + 1;
  endfunction

endpackage

// File: rtl/md_audio_mixer_if.sv
// md_audio_mixer sample bus: FM/PSG inputs, mute, PCM outputs.
// master drives the inputs; slave is the mixer.
interface md_audio_mixer_if;
  logic signed [8:0]  MOL;
  logic signed [8:0]  MOR;
  logic        [15:0] PSG;
  logic               MUTE;
  logic signed [15:0] AUD_L;
  logic signed [15:0] AUD_R;
  logic               AUD_STB;
  logic               AUD_OVF;

  modport master (
    output MOL, MOR, PSG, MUTE,
    input  AUD_L, AUD_R, AUD_STB, AUD_OVF
  );

  modport slave (
    input  MOL, MOR, PSG, MUTE,
    output AUD_L, AUD_R, AUD_STB, AUD_OVF
  );
endinterface

// File: rtl/md_audio_dcblock.sv
// md_audio_mixer per-channel DC blocker (used with MD_AUDIO_DCBLOCK_EN).
// y = x - x_prev + y_prev - (y_prev >>> 9), 18-bit, saturated to 16.
module md_audio_dcblock
  import md_audio_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic signed [15:0] i_x,
  output logic signed [15:0] o_y,
  output logic               o_clip
);

  logic signed [15:0] r_xp;
  logic signed [15:0] r_yp;
  logic signed [17:0] w_y;

  assign w_y = 18'(i_x) - 18'(r_xp)
             + 18'(r_yp) - 18'(r_yp >>> DC_SHIFT);

  always_comb begin
    o_clip = 1'b0;
    o_y    = w_y[15:0];
    if (w_y > 18'(SAT_MAX)) begin
      o_clip = 1'b1;
      o_y    = 16'sh7fff;
    end else if (w_y < 18'(SAT_MIN)) begin
      o_clip = 1'b1;
      o_y    = 16'sh8000;
    end
  end

  // filter state tracks the clipped output, independent of mute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xp <= '0;
      r_yp <= '0;
    end else if (i_en) begin
      r_xp <= i_x;
      r_yp <= o_y;
    end
  end

endmodule

// File: rtl/md_audio_mixer.sv
// md_audio_mixer: box-filter/decimate FM+PSG, gain, shift, saturate.
// Optional DC blocker stage enabled by MD_AUDIO_DCBLOCK_EN.
module md_audio_mixer
  import md_audio_pkg::*;
#(
  parameter int          DECIM    = 1008,
  parameter int unsigned FM_GAIN  = 16,
  parameter int unsigned PSG_GAIN = 4,
  parameter int          SHIFT    = 8
) (
  input logic        MCLK,
  input logic        SRES_n,
  md_audio_mixer_if.slave bus
);

  localparam int CW  = $clog2(DECIM);
  localparam int FW  = acc_width(9, DECIM);
  localparam int PW  = acc_width(12, DECIM);
  localparam int MW  = (FW > PW) ? FW : PW;
  localparam int PRW = prod_width(MW);
  localparam int SW  = PRW + 1;

  logic [CW-1:0]      r_cnt;
  logic               w_last;
  logic signed [11:0] w_psg;
  logic signed [FW-1:0] w_mol, w_mor;
  logic signed [PW-1:0] w_psx;
  logic signed [FW-1:0] r_acc_l, r_acc_r;
  logic signed [FW-1:0] r_hold_l, r_hold_r;
  logic signed [PW-1:0] r_acc_p, r_hold_p;

  assign w_last = (r_cnt == CW'(DECIM - 1));
  assign w_psg  = $signed({1'b0, bus.PSG[15:5]}
                          - 12'(PSG_BIAS));
  assign w_mol  = FW'(bus.MOL);
  assign w_mor  = FW'(bus.MOR);
  assign w_psx  = PW'(w_psg);

  // accumulation never stalls; the boundary sample goes into the hold
  always_ff @(posedge MCLK or negedge SRES_n) begin
    if (!SRES_n) begin
      r_cnt    <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      r_acc_p  <= '0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_hold_p <= '0;
    end else if (w_last) begin
      r_cnt    <= '0;
      r_hold_l <= r_acc_l + w_mol;
      r_hold_r <= r_acc_r + w_mor;
      r_hold_p <= r_acc_p + w_psx;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      r_acc_p  <= '0;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
      r_acc_l <= r_acc_l + w_mol;
      r_acc_r <= r_acc_r + w_mor;
      r_acc_p <= r_acc_p + w_psx;
    end
  end

  seq_t r_state, w_next;
  logic signed [PRW-1:0] w_ma, w_mb, w_mul;
  logic signed [PRW-1:0] r_prod_l, r_prod_r, r_prod_p;

  always_ff @(posedge MCLK or negedge SRES_n) begin
    if (!SRES_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ma   = '0;
    w_mb   = '0;
    case (r_state)
      S_IDLE: if (w_last) w_next = S_P1;
      S_P1: begin
        w_next = S_P2;
        w_ma   = PRW'(r_hold_p);
        w_mb   = PRW'(PSG_GAIN);
      end
      S_P2: begin
        w_next = S_P3;
        w_ma   = PRW'(r_hold_l);
        w_mb   = PRW'(FM_GAIN);
      end
      S_P3: begin
        w_next = S_P4;
        w_ma   = PRW'(r_hold_r);
        w_mb   = PRW'(FM_GAIN);
      end
`ifdef MD_AUDIO_DCBLOCK_EN
      S_P4:    w_next = S_DC;
`else
      S_P4:    w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  assign w_mul = w_ma * w_mb;

  always_ff @(posedge MCLK or negedge SRES_n) begin
    if (!SRES_n) begin
      r_prod_p <= '0;
      r_prod_l <= '0;
      r_prod_r <= '0;
    end else begin
      if (r_state == S_P1) r_prod_p <= w_mul;
      if (r_state == S_P2) r_prod_l <= w_mul;
      if (r_state == S_P3) r_prod_r <= w_mul;
    end
  end

  function automatic logic [16:0] sat16(
    input logic signed [SW-1:0] v
  );
    logic signed [SW-1:0] s;
    s = v >>> SHIFT;
    if (s > SW'(SAT_MAX))      return {1'b1, 16'h7fff};
    else if (s < SW'(SAT_MIN)) return {1'b1, 16'h8000};
    else                       return {1'b0, s[15:0]};
  endfunction

  logic signed [SW-1:0] w_sum_l, w_sum_r;
  logic [16:0]          w_sat_l, w_sat_r;

  assign w_sum_l = SW'(r_prod_l) + SW'(r_prod_p);
  assign w_sum_r = SW'(r_prod_r) + SW'(r_prod_p);
  assign w_sat_l = sat16(w_sum_l);
  assign w_sat_r = sat16(w_sum_r);

  logic               w_out_en;
  logic signed [15:0] w_out_l, w_out_r;
  logic               w_out_ovf;

`ifdef MD_AUDIO_DCBLOCK_EN
  logic signed [15:0] r_xl, r_xr;
  logic               r_xclip;
  logic signed [15:0] w_yl, w_yr;
  logic               w_cl, w_cr;

  always_ff @(posedge MCLK or negedge SRES_n) begin
    if (!SRES_n) begin
      r_xl    <= '0;
      r_xr    <= '0;
      r_xclip <= 1'b0;
    end else if (r_state == S_P4) begin
      r_xl    <= w_sat_l[15:0];
      r_xr    <= w_sat_r[15:0];
      r_xclip <= w_sat_l[16] | w_sat_r[16];
    end
  end

  md_audio_dcblock u_dc_l (
    .clk    (MCLK),
    .rst_n  (SRES_n),
    .i_en   (w_out_en),
    .i_x    (r_xl),
    .o_y    (w_yl),
    .o_clip (w_cl)
  );

  md_audio_dcblock u_dc_r (
    .clk    (MCLK),
    .rst_n  (SRES_n),
    .i_en   (w_out_en),
    .i_x    (r_xr),
    .o_y    (w_yr),
    .o_clip (w_cr)
  );

  assign w_out_en  = (r_state == S_DC);
  assign w_out_l   = w_yl;
  assign w_out_r   = w_yr;
  assign w_out_ovf = r_xclip | w_cl | w_cr;
`else
  assign w_out_en  = (r_state == S_P4);
  assign w_out_l   = w_sat_l[15:0];
  assign w_out_r   = w_sat_r[15:0];
  assign w_out_ovf = w_sat_l[16] | w_sat_r[16];
`endif

  logic signed [15:0] r_aud_l, r_aud_r;
  logic               r_stb, r_ovf;

  always_ff @(posedge MCLK or negedge SRES_n) begin
    if (!SRES_n) begin
      r_aud_l <= '0;
      r_aud_r <= '0;
      r_stb   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_stb <= w_out_en;
      if (w_out_en) begin
        r_aud_l <= bus.MUTE ? '0 : w_out_l;
        r_aud_r <= bus.MUTE ? '0 : w_out_r;
        r_ovf   <= bus.MUTE ? 1'b0 : w_out_ovf;
      end
    end
  end

  assign bus.AUD_L   = r_aud_l;
  assign bus.AUD_R   = r_aud_r;
  assign bus.AUD_STB = r_stb;
  assign bus.AUD_OVF = r_ovf;

endmodule

// File: tb/tb_md_audio_mixer.sv
// md_audio_mixer directed testbench: default-gain and FM_GAIN=64
// instances share clock and reset.
module tb_md_audio_mixer;

  logic MCLK   = 1'b0;
  logic SRES_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   edge_n;
  int   at;

  always #5 MCLK = ~MCLK;

  md_audio_mixer_if bus ();
  md_audio_mixer_if bus_g ();

  md_audio_mixer dut (
    .MCLK   (MCLK),
    .SRES_n (SRES_n),
    .bus    (bus)
  );

  md_audio_mixer #(.FM_GAIN(64)) dut_g (
    .MCLK   (MCLK),
    .SRES_n (SRES_n),
    .bus    (bus_g)
  );

  always @(posedge MCLK or negedge SRES_n) begin
    if (!SRES_n) edge_n <= 0;
    else         edge_n <= edge_n + 1;
  end

  task automatic set_a(input logic signed [8:0] l,
                       input logic signed [8:0] r,
                       input logic [15:0] p);
    bus.MOL = l;
    bus.MOR = r;
    bus.PSG = p;
  endtask

  task automatic set_g(input logic signed [8:0] l,
                       input logic signed [8:0] r,
                       input logic [15:0] p);
    bus_g.MOL = l;
    bus_g.MOR = r;
    bus_g.PSG = p;
  endtask

  task automatic do_reset;
    @(negedge MCLK);
    SRES_n = 1'b0;
    repeat (2) @(negedge MCLK);
    SRES_n = 1'b1;
  endtask

  task automatic wait_stb(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      @(negedge MCLK);
      if (bus.AUD_STB === 1'b1) t = edge_n;
    end
  endtask

  task automatic test_reset;
    set_a(9'sd100, -9'sd100, 16'h8000);
    set_g(9'sd0, 9'sd0, 16'h8000);
    bus.MUTE   = 1'b0;
    bus_g.MUTE = 1'b0;
    repeat (3) @(negedge MCLK);
    SRES_n = 1'b0;
    #1;
    checks++;
    if (bus.AUD_L !== 16'sd0) begin
      errors++; $display("FAIL rst_l got %0d want 0", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== 16'sd0) begin
      errors++; $display("FAIL rst_r got %0d want 0", bus.AUD_R);
    end
    checks++;
    if (bus.AUD_STB !== 1'b0) begin
      errors++; $display("FAIL rst_stb got %b want 0", bus.AUD_STB);
    end
    checks++;
    if (bus.AUD_OVF !== 1'b0) begin
      errors++; $display("FAIL rst_ovf got %b want 0", bus.AUD_OVF);
    end
    repeat (2) @(negedge MCLK);
    SRES_n = 1'b1;
  endtask

  task automatic test_basic;
    wait_stb(1100, at);
    checks++;
    if (at !== 1012) begin
      errors++; $display("FAIL first_stb edge got %0d want 1012", at);
    end
    checks++;
    if (bus.AUD_L !== 16'sd6300) begin
      errors++; $display("FAIL basic_l got %0d want 6300", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== -16'sd6300) begin
      errors++; $display("FAIL basic_r got %0d want -6300", bus.AUD_R);
    end
    checks++;
    if (bus.AUD_OVF !== 1'b0) begin
      errors++; $display("FAIL basic_ovf got %b want 0", bus.AUD_OVF);
    end
    @(negedge MCLK);
    checks++;
    if (bus.AUD_STB !== 1'b0) begin
      errors++; $display("FAIL stb_width got %b want 0", bus.AUD_STB);
    end
    wait_stb(1100, at);
    checks++;
    if (at !== 2020) begin
      errors++; $display("FAIL second_stb edge got %0d want 2020", at);
    end
    checks++;
    if (bus.AUD_L !== 16'sd6300) begin
      errors++; $display("FAIL basic2_l got %0d want 6300", bus.AUD_L);
    end
  endtask

  task automatic test_psg;
    set_a(9'sd0, 9'sd0, 16'hFFFF);
    set_g(9'sd0, 9'sd0, 16'h7FE0);
    do_reset();
    wait_stb(1100, at);
    checks++;
    if (at !== 1012) begin
      errors++; $display("FAIL psg_stb edge got %0d want 1012", at);
    end
    checks++;
    if (bus.AUD_L !== 16'sd16112) begin
      errors++; $display("FAIL psg_l got %0d want 16112", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== 16'sd16112) begin
      errors++; $display("FAIL psg_r got %0d want 16112", bus.AUD_R);
    end
    checks++;
    if (bus_g.AUD_L !== -16'sd16) begin
      errors++; $display("FAIL psg_floor_l got %0d want -16", bus_g.AUD_L);
    end
    checks++;
    if (bus_g.AUD_R !== -16'sd16) begin
      errors++; $display("FAIL psg_floor_r got %0d want -16", bus_g.AUD_R);
    end
  endtask

  task automatic test_saturation;
    set_a(9'sd255, -9'sd256, 16'h8000);
    set_g(9'sd255, -9'sd256, 16'h8000);
    do_reset();
    wait_stb(1100, at);
    checks++;
    if (bus.AUD_L !== 16'sd16065) begin
      errors++; $display("FAIL nosat_l got %0d want 16065", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== -16'sd16128) begin
      errors++; $display("FAIL nosat_r got %0d want -16128", bus.AUD_R);
    end
    checks++;
    if (bus.AUD_OVF !== 1'b0) begin
      errors++; $display("FAIL nosat_ovf got %b want 0", bus.AUD_OVF);
    end
    checks++;
    if (bus_g.AUD_L !== 16'sd32767) begin
      errors++; $display("FAIL sat_l got %0d want 32767", bus_g.AUD_L);
    end
    checks++;
    if (bus_g.AUD_R !== -16'sd32768) begin
      errors++; $display("FAIL sat_r got %0d want -32768", bus_g.AUD_R);
    end
    checks++;
    if (bus_g.AUD_OVF !== 1'b1) begin
      errors++; $display("FAIL sat_ovf got %b want 1", bus_g.AUD_OVF);
    end
  endtask

  task automatic test_reset_mid;
    set_a(-9'sd200, 9'sd50, 16'h8000);
    do_reset();
    wait_stb(1100, at);
    checks++;
    if (bus.AUD_L !== -16'sd12600) begin
      errors++; $display("FAIL pre_l got %0d want -12600", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== 16'sd3150) begin
      errors++; $display("FAIL pre_r got %0d want 3150", bus.AUD_R);
    end
    for (int i = 0; i < 1000 && edge_n < 1508; i++) @(negedge MCLK);
    set_a(9'sd100, -9'sd100, 16'h8000);
    SRES_n = 1'b0;
    #1;
    checks++;
    if (bus.AUD_L !== 16'sd0) begin
      errors++; $display("FAIL mid_rst_l got %0d want 0", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== 16'sd0) begin
      errors++; $display("FAIL mid_rst_r got %0d want 0", bus.AUD_R);
    end
    checks++;
    if (bus_g.AUD_OVF !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ovf got %b want 0", bus_g.AUD_OVF);
    end
    repeat (2) @(negedge MCLK);
    SRES_n = 1'b1;
    wait_stb(1100, at);
    checks++;
    if (at !== 1012) begin
      errors++; $display("FAIL post_rst_stb edge got %0d want 1012", at);
    end
    checks++;
    if (bus.AUD_L !== 16'sd6300) begin
      errors++; $display("FAIL post_rst_l got %0d want 6300", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== -16'sd6300) begin
      errors++; $display("FAIL post_rst_r got %0d want -6300", bus.AUD_R);
    end
  endtask

  task automatic test_mute;
    set_a(9'sd100, -9'sd100, 16'h8000);
    set_g(9'sd255, -9'sd256, 16'h8000);
    bus.MUTE   = 1'b1;
    bus_g.MUTE = 1'b1;
    do_reset();
    wait_stb(1100, at);
    checks++;
    if (at !== 1012) begin
      errors++; $display("FAIL mute_stb edge got %0d want 1012", at);
    end
    checks++;
    if (bus.AUD_L !== 16'sd0) begin
      errors++; $display("FAIL mute_l got %0d want 0", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== 16'sd0) begin
      errors++; $display("FAIL mute_r got %0d want 0", bus.AUD_R);
    end
    checks++;
    if (bus_g.AUD_OVF !== 1'b0) begin
      errors++; $display("FAIL mute_ovf got %b want 0", bus_g.AUD_OVF);
    end
    checks++;
    if (bus_g.AUD_L !== 16'sd0) begin
      errors++; $display("FAIL mute_g_l got %0d want 0", bus_g.AUD_L);
    end
    bus.MUTE   = 1'b0;
    bus_g.MUTE = 1'b0;
    wait_stb(1100, at);
    checks++;
    if (at !== 2020) begin
      errors++; $display("FAIL unmute_stb edge got %0d want 2020", at);
    end
    checks++;
    if (bus.AUD_L !== 16'sd6300) begin
      errors++; $display("FAIL unmute_l got %0d want 6300", bus.AUD_L);
    end
    checks++;
    if (bus.AUD_R !== -16'sd6300) begin
      errors++; $display("FAIL unmute_r got %0d want -6300", bus.AUD_R);
    end
    checks++;
    if (bus_g.AUD_OVF !== 1'b1) begin
      errors++; $display("FAIL unmute_ovf got %b want 1", bus_g.AUD_OVF);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_psg();
    test_saturation();
    test_reset_mid();
    test_mute();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
